// File: rtl/alu64_flags.sv
// 64-bit execute-stage ALU: combinational result, zero, carry and overflow,
// plus an NZCV flag register that loads on request.
module alu64_flags #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [3:0]       alu_signal,
   input  logic             flag_we,
   output logic [WIDTH-1:0] alu_result,
   output logic             ZERO_FLAG,
   output logic             carry_out,
   output logic             overflow,
   output logic [3:0]       nzcv_q
);

   localparam logic [3:0] OpAnd   = 4'b0000;
   localparam logic [3:0] OpOr    = 4'b0001;
   localparam logic [3:0] OpAdd   = 4'b0010;
   localparam logic [3:0] OpSub   = 4'b0110;
   localparam logic [3:0] OpPassB = 4'b0111;
   localparam logic [3:0] OpNor   = 4'b1100;

   logic [WIDTH-1:0] b_op;
   logic             carry_in;
   logic [WIDTH:0]   sum_ext;
   logic             a_sign;
   logic             b_sign;
   logic             s_sign;
   logic [3:0]       nzcv_d;

   // One shared adder: SUB is a + ~b + 1, so carry_out means no-borrow.
   always_comb begin
      b_op     = data_b;
      carry_in = 1'b0;
      if (alu_signal == OpSub) begin
         b_op     = ~data_b;
         carry_in = 1'b1;
      end
      sum_ext = {1'b0, data_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
   end

   assign a_sign = data_a[WIDTH-1];
   assign b_sign = data_b[WIDTH-1];
   assign s_sign = sum_ext[WIDTH-1];

   always_comb begin
      alu_result = '0;
      carry_out  = 1'b0;
      overflow   = 1'b0;
      case (alu_signal)
         OpAnd:   alu_result = data_a & data_b;
         OpOr:    alu_result = data_a | data_b;
         OpAdd: begin
            alu_result = sum_ext[WIDTH-1:0];
            carry_out  = sum_ext[WIDTH];
            overflow   = (a_sign == b_sign) && (s_sign != a_sign);
         end
         OpSub: begin
            alu_result = sum_ext[WIDTH-1:0];
            carry_out  = sum_ext[WIDTH];
            overflow   = (a_sign != b_sign) && (s_sign != a_sign);
         end
         OpPassB: alu_result = data_b;
         OpNor:   alu_result = ~(data_a | data_b);
         default: alu_result = '0;
      endcase
   end

   assign ZERO_FLAG = ~|alu_result;

   always_comb begin
      nzcv_d = nzcv_q;
      if (flag_we) begin
         nzcv_d = {alu_result[WIDTH-1], ZERO_FLAG, carry_out, overflow};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nzcv_q <= 4'b0000;
      end else begin
         nzcv_q <= nzcv_d;
      end
   end

endmodule

// File: tb/tb_alu64_flags.sv
// Self-checking bench for alu64_flags: directed corner cases, then random
// operations compared against an arithmetic reference model.
module tb_alu64_flags;

   localparam int unsigned W = 64;

   logic         clk;
   logic         reset;
   logic [W-1:0] data_a;
   logic [W-1:0] data_b;
   logic [3:0]   alu_signal;
   logic         flag_we;
   logic [W-1:0] alu_result;
   logic         ZERO_FLAG;
   logic         carry_out;
   logic         overflow;
   logic [3:0]   nzcv_q;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [3:0]  exp_nzcv;

   alu64_flags #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_a     (data_a),
      .data_b     (data_b),
      .alu_signal (alu_signal),
      .flag_we    (flag_we),
      .alu_result (alu_result),
      .ZERO_FLAG  (ZERO_FLAG),
      .carry_out  (carry_out),
      .overflow   (overflow),
      .nzcv_q     (nzcv_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: carry and overflow from true unsigned/signed arithmetic ranges.
   task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic c, output logic v);
      logic [W:0]          uwide;
      logic signed [W+1:0] swide;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            uwide = {1'b0, a} + {1'b0, b};
            r     = uwide[W-1:0];
            c     = (uwide > {1'b0, {W{1'b1}}});
            swide = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
         end
         4'b0110: begin
            r     = a - b;
            c     = (a >= b);
            swide = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
         end
         4'b0111: r = b;
         4'b1100: r = ~(a | b);
         default: r = '0;
      endcase
      if (op == 4'b0010 || op == 4'b0110) begin
         v = (swide > $signed({2'b00, 1'b0, {(W-1){1'b1}}})) ||
             (swide < $signed({2'b11, 1'b1, {(W-1){1'b0}}}));
      end
   endtask

   task automatic apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      alu_signal = op;
      data_a     = a;
      data_b     = b;
      #1;
   endtask

   task automatic check_comb(input string tag);
      logic [W-1:0] r;
      logic         c;
      logic         v;
      model(alu_signal, data_a, data_b, r, c, v);
      check_eq({tag, ".res"}, alu_result, r);
      check_eq({tag, ".z"}, {63'd0, ZERO_FLAG}, {63'd0, (r == '0)});
      check_eq({tag, ".c"}, {63'd0, carry_out}, {63'd0, c});
      check_eq({tag, ".v"}, {63'd0, overflow}, {63'd0, v});
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] corners [5];
      corners[0] = '0;
      corners[1] = 64'd1;
      corners[2] = '1;
      corners[3] = 64'h7FFF_FFFF_FFFF_FFFF;
      corners[4] = 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return {$urandom, $urandom};
   endfunction

   initial begin
      reset      = 1'b1;
      flag_we    = 1'b0;
      alu_signal = 4'b0000;
      data_a     = '0;
      data_b     = '0;
      exp_nzcv   = 4'b0000;

      // Reset state; combinational path stays live during reset.
      apply(4'b0010, 64'd3, 64'd4);
      check_eq("reset.nzcv", {60'd0, nzcv_q}, 64'd0);
      check_eq("reset.add", alu_result, 64'd7);
      @(negedge clk);
      reset = 1'b0;

      // Directed table.
      apply(4'b0000, 64'hFF00FF00FF00FF00, 64'h00FF00FF00FF00FF); check_comb("and");
      check_eq("and.z1", {63'd0, ZERO_FLAG}, 64'd1);
      apply(4'b0001, 64'hFF00FF00FF00FF00, 64'h00FF00FF00FF00FF); check_comb("or");
      check_eq("or.val", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
      apply(4'b0010, 64'd100, 64'd50); check_comb("add");
      check_eq("add.val", alu_result, 64'd150);
      apply(4'b0110, 64'd100, 64'd50); check_comb("sub");
      check_eq("sub.c1", {63'd0, carry_out}, 64'd1);
      apply(4'b0110, 64'd42, 64'd42); check_comb("sub_eq");
      check_eq("sub_eq.z1", {63'd0, ZERO_FLAG}, 64'd1);
      apply(4'b0111, 64'hDEADBEEFCAFEBABE, 64'h1122334455667788); check_comb("passb");
      check_eq("passb.val", alu_result, 64'h1122334455667788);
      apply(4'b1100, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000); check_comb("nor");
      apply(4'b0010, '1, 64'd1); check_comb("add_wrap");
      check_eq("add_wrap.c1", {63'd0, carry_out}, 64'd1);
      apply(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); check_comb("add_ovf");
      check_eq("add_ovf.v1", {63'd0, overflow}, 64'd1);
      apply(4'b0110, 64'd0, 64'd1); check_comb("sub_wrap");
      check_eq("sub_wrap.val", alu_result, '1);
      apply(4'b1010, 64'd123, 64'd456); check_comb("undef");
      check_eq("undef.z1", {63'd0, ZERO_FLAG}, 64'd1);

      // NZCV load: SUB 0 - 1 -> N=1 Z=0 C=0 V=0.
      @(negedge clk);
      apply(4'b0110, 64'd0, 64'd1);
      flag_we = 1'b1;
      @(posedge clk); #1;
      check_eq("nzcv.load", {60'd0, nzcv_q}, 64'h8);
      @(negedge clk);
      flag_we = 1'b0;
      apply(4'b0110, 64'd42, 64'd42);
      @(posedge clk); #1;
      check_eq("nzcv.hold", {60'd0, nzcv_q}, 64'h8);

      // Asynchronous reset mid-cycle, held across an enabled edge.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_eq("nzcv.async_rst", {60'd0, nzcv_q}, 64'd0);
      flag_we = 1'b1;
      apply(4'b0110, 64'd0, 64'd1);
      @(posedge clk); #1;
      check_eq("nzcv.rst_hold", {60'd0, nzcv_q}, 64'd0);
      @(negedge clk);
      reset    = 1'b0;
      flag_we  = 1'b0;
      exp_nzcv = 4'b0000;

      // Random operations with randomized flag writes.
      for (int i = 0; i < 300; i++) begin
         logic [3:0]   op;
         logic [W-1:0] r;
         logic         c;
         logic         v;
         logic [3:0]   codes [7];
         codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
         codes[4] = 4'b0111; codes[5] = 4'b1100; codes[6] = 4'($urandom_range(0, 15));
         op = codes[$urandom_range(0, 6)];
         @(negedge clk);
         flag_we = 1'($urandom_range(0, 1));
         apply(op, pick_operand(), pick_operand());
         check_comb("rand");
         model(op, data_a, data_b, r, c, v);
         if (flag_we) exp_nzcv = {r[W-1], (r == '0), c, v};
         @(posedge clk); #1;
         check_eq("rand.nzcv", {60'd0, nzcv_q}, {60'd0, exp_nzcv});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
